ctrl_pipe_unit: RTL and testbench

- Parametrised successor to the combinational main-control decoder.
- Decodes the ID-stage opcode into EX/MEM/WB control fields and carries them through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles; squashes wrong-path instructions on a taken branch or jump.
- Sits between the fetch/decode front end and the datapath stage registers.

---
 rtl/ctrl_pkg.sv | 44 ++++
 rtl/ctrl_pipe_unit_if.sv | 43 ++++
 rtl/ctrl_decode.sv | 63 ++++++
 rtl/ctrl_pipe_unit.sv | 97 +++++++++
 tb/tb_ctrl_pipe_unit.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode map, ALU source encodings and per-stage control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_ADDI = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SLTI = 4'd6;
   localparam logic [3:0] OP_LW   = 4'd7;
   localparam logic [3:0] OP_LB   = 4'd8;
   localparam logic [3:0] OP_SW   = 4'd9;
   localparam logic [3:0] OP_SB   = 4'd10;
   localparam logic [3:0] OP_LUI  = 4'd11;
   localparam logic [3:0] OP_ORI  = 4'd12;
   localparam logic [3:0] OP_CMP  = 4'd13;
   localparam logic [3:0] OP_BNE  = 4'd14;
   localparam logic [3:0] OP_JMP  = 4'd15;

   // ALU second-operand source
   typedef enum logic [1:0] {
      SRC_REG   = 2'b00,
      SRC_IMM   = 2'b01,
      SRC_OFS   = 2'b10,
      SRC_UPPER = 2'b11
   } alu_src_t;

   // Decoded alu_op never needs more than 3 bits; widened at the outputs.
   typedef struct packed {
      alu_src_t   alu_src;
      logic [2:0] alu_op;
      logic       mem_write;
      logic       bne;
      logic       jump;
      logic       mem_to_reg;
      logic       reg_write;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// Front-end / datapath bundle of the control pipe; stall/flush are the only flow control.
// Latency: n/a (wires only).
// Backpressure: stall is driven by the unit; CTRL_PERF_CNT_EN adds the perf counter outputs.
interface ctrl_pipe_unit_if #(
   parameter int OPW    = 4,
   parameter int RAW    = 3,
   parameter int ALUOPW = 3
);
   logic              id_valid;
   logic [OPW-1:0]    id_opcode;
   logic [RAW-1:0]    id_rs;
   logic [RAW-1:0]    id_rt;
   logic [RAW-1:0]    id_rd;
   logic              flush;
   logic              stall;
   logic [1:0]        ex_alu_src;
   logic [ALUOPW-1:0] ex_alu_op;
   logic              mem_write;
   logic              mem_bne;
   logic              mem_jump;
   logic              wb_mem_to_reg;
   logic              wb_reg_write;
   logic [RAW-1:0]    wb_rd;
   logic              illegal;
`ifdef CTRL_PERF_CNT_EN
   logic [15:0]       stall_cnt;
   logic [15:0]       flush_cnt;

   modport master (output id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
                   input  stall, ex_alu_src, ex_alu_op, mem_write, mem_bne, mem_jump,
                          wb_mem_to_reg, wb_reg_write, wb_rd, illegal, stall_cnt, flush_cnt);
   modport slave  (input  id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
                   output stall, ex_alu_src, ex_alu_op, mem_write, mem_bne, mem_jump,
                          wb_mem_to_reg, wb_reg_write, wb_rd, illegal, stall_cnt, flush_cnt);
`else
   modport master (output id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
                   input  stall, ex_alu_src, ex_alu_op, mem_write, mem_bne, mem_jump,
                          wb_mem_to_reg, wb_reg_write, wb_rd, illegal);
   modport slave  (input  id_valid, id_opcode, id_rs, id_rt, id_rd, flush,
                   output stall, ex_alu_src, ex_alu_op, mem_write, mem_bne, mem_jump,
                          wb_mem_to_reg, wb_reg_write, wb_rd, illegal);
`endif
endinterface

// File: rtl/ctrl_decode.sv
// Pure opcode -> ctrl_t decoder; reserved opcodes (>= 16) decode to CTRL_NOP.
// Latency: combinational.
// Backpressure: none.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic [OPW-1:0] opcode,
   output ctrl_t          ctrl,
   output logic           reserved
);

   logic [31:0] op_ext;
   logic [3:0]  op;

   assign op_ext   = 32'(opcode);
   assign op       = op_ext[3:0];
   assign reserved = (op_ext > 32'd15);

   // Opcode table; anything reserved stays a NOP
   always_comb begin
      ctrl = CTRL_NOP;
      if (!reserved) begin
         case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
               ctrl.alu_op    = op[2:0];
               ctrl.reg_write = 1'b1;
            end
            OP_ADDI, OP_SLTI: begin
               ctrl.alu_src   = SRC_IMM;
               ctrl.alu_op    = op[2:0];
               ctrl.reg_write = 1'b1;
            end
            OP_LW, OP_LB: begin
               ctrl.alu_src    = SRC_OFS;
               ctrl.mem_to_reg = 1'b1;
               ctrl.reg_write  = 1'b1;
            end
            OP_SW, OP_SB: begin
               ctrl.alu_src    = SRC_OFS;
               ctrl.mem_write  = 1'b1;
               ctrl.mem_to_reg = 1'b1;
            end
            OP_LUI: begin
               ctrl.alu_src   = SRC_UPPER;
               ctrl.alu_op    = 3'b111;
               ctrl.reg_write = 1'b1;
            end
            OP_ORI: begin
               ctrl.alu_src   = SRC_IMM;
               ctrl.alu_op    = 3'b111;
               ctrl.reg_write = 1'b1;
            end
            OP_CMP:  ctrl.alu_op = 3'b010;
            OP_BNE:  ctrl.bne    = 1'b1;
            OP_JMP:  ctrl.jump   = 1'b1;
            default: ctrl = CTRL_NOP;
         endcase
      end
   end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Decodes ID opcode and carries controls through ID/EX, EX/MEM, MEM/WB; load-use stall, flush squash.
// Latency: EX controls 1 cycle, MEM 2 cycles, WB 3 cycles after ID.
// Backpressure: stall holds PC/IF-ID for one cycle on load-use; flush (wins over stall) bubbles EX and MEM. Optional CTRL_PERF_CNT_EN.
module ctrl_pipe_unit
   import ctrl_pkg::*;
#(
   parameter int OPW    = 4,
   parameter int RAW    = 3,
   parameter int ALUOPW = 3
) (
   input logic              clk,
   input logic              reset,
   ctrl_pipe_unit_if.slave  bus
);

   typedef struct packed {
      logic           valid;
      ctrl_t          ctrl;
      logic [RAW-1:0] rd;
   } stage_t;

   stage_t ex_q, mem_q, wb_q;
   stage_t id_entry;
   ctrl_t  id_ctrl;
   logic   id_reserved;
   logic   hazard;

   ctrl_decode #(.OPW(OPW)) u_decode (
      .opcode   (bus.id_opcode),
      .ctrl     (id_ctrl),
      .reserved (id_reserved)
   );

   // A load in EX whose result ID wants right now cannot be forwarded in time
   assign hazard = bus.id_valid & ex_q.valid & ex_q.ctrl.mem_to_reg & ex_q.ctrl.reg_write &
                   ((ex_q.rd == bus.id_rs) | (ex_q.rd == bus.id_rt));

   assign bus.stall   = hazard & ~bus.flush;
   assign bus.illegal = bus.id_valid & id_reserved;

   // Build the ID entry; empty slots carry all-zero fields
   always_comb begin
      id_entry = '0;
      if (bus.id_valid) begin
         id_entry.valid = 1'b1;
         id_entry.ctrl  = id_ctrl;
         id_entry.rd    = bus.id_rd;
      end
   end

   // Stage registers: hazard bubbles EX only, flush bubbles EX and MEM, WB always advances
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= (bus.flush | hazard) ? '0 : id_entry;
         mem_q <= bus.flush ? '0 : ex_q;
         wb_q  <= mem_q;
      end
   end

   assign bus.ex_alu_src    = ex_q.valid  ? ex_q.ctrl.alu_src            : SRC_REG;
   assign bus.ex_alu_op     = ex_q.valid  ? ALUOPW'(ex_q.ctrl.alu_op)    : '0;
   assign bus.mem_write     = mem_q.valid & mem_q.ctrl.mem_write;
   assign bus.mem_bne       = mem_q.valid & mem_q.ctrl.bne;
   assign bus.mem_jump      = mem_q.valid & mem_q.ctrl.jump;
   assign bus.wb_mem_to_reg = wb_q.valid  & wb_q.ctrl.mem_to_reg;
   assign bus.wb_reg_write  = wb_q.valid  & wb_q.ctrl.reg_write;
   assign bus.wb_rd         = wb_q.valid  ? wb_q.rd : '0;

   // WB only consumes the write-back fields; the rest of the bundle dies here
   logic unused_wb_bits;
   assign unused_wb_bits = ^{wb_q.ctrl.alu_src, wb_q.ctrl.alu_op, wb_q.ctrl.mem_write,
                             wb_q.ctrl.bne, wb_q.ctrl.jump};

`ifdef CTRL_PERF_CNT_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] flush_cnt_q;

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (bus.stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
         if (bus.flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Self-checking bench for ctrl_pipe_unit: directed scenarios plus random traffic vs a behavioural model.
// Latency: n/a.
// Backpressure: the bench acts as front end and holds ID while stall is seen.
module tb_ctrl_pipe_unit;

   localparam int OPW    = 5;
   localparam int RAW    = 3;
   localparam int ALUOPW = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   ctrl_pipe_unit_if #(.OPW(OPW), .RAW(RAW), .ALUOPW(ALUOPW)) bus();

   ctrl_pipe_unit #(.OPW(OPW), .RAW(RAW), .ALUOPW(ALUOPW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit v;
      int src;
      int aop;
      bit mw;
      bit bne;
      bit jmp;
      bit m2r;
      bit rw;
      int rd;
   } ent_t;

   ent_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   checking = 0;
   bit   last_stall = 0;
`ifdef CTRL_PERF_CNT_EN
   int   m_stall_cnt = 0;
   int   m_flush_cnt = 0;
`endif

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic ent_t empty_ent();
      ent_t e;
      e.v = 0; e.src = 0; e.aop = 0; e.mw = 0; e.bne = 0;
      e.jmp = 0; e.m2r = 0; e.rw = 0; e.rd = 0;
      return e;
   endfunction

   // Opcode rules written straight from the opcode table
   function automatic ent_t ref_decode(input int op, input int rd);
      ent_t e = empty_ent();
      e.v  = 1;
      e.rd = rd;
      if (op > 15) return e;
      if (op == 3 || op == 6 || op == 12) e.src = 1;
      else if (op >= 7 && op <= 10)       e.src = 2;
      else if (op == 11)                  e.src = 3;
      if (op < 7)                         e.aop = op;
      else if (op == 11 || op == 12)      e.aop = 7;
      else if (op == 13)                  e.aop = 2;
      e.mw  = (op == 9 || op == 10);
      e.bne = (op == 14);
      e.jmp = (op == 15);
      e.m2r = (op >= 7 && op <= 10);
      e.rw  = (op <= 8 || op == 11 || op == 12);
      return e;
   endfunction

   task automatic drive(input bit v, input int op, input int rs, input int rt, input int rd,
                        input bit fl, input bit rst);
      bus.id_valid  = v;
      bus.id_opcode = OPW'(op);
      bus.id_rs     = RAW'(rs);
      bus.id_rt     = RAW'(rt);
      bus.id_rd     = RAW'(rd);
      bus.flush     = fl;
      reset         = rst;
   endtask

   // One clock: compare outputs at the falling edge, then advance the model
   task automatic step();
      bit   hz, e_stall, e_ill;
      ent_t ex;
      @(negedge clk);
      ex      = pipe[0];
      hz      = bus.id_valid && ex.v && ex.m2r && ex.rw &&
                (ex.rd == int'(bus.id_rs) || ex.rd == int'(bus.id_rt));
      e_stall = hz && !bus.flush;
      e_ill   = bus.id_valid && (int'(bus.id_opcode) >= 16);
      if (checking) begin
         check_eq("stall",         bus.stall,         e_stall);
         check_eq("illegal",       bus.illegal,       e_ill);
         check_eq("ex_alu_src",    bus.ex_alu_src,    pipe[0].src);
         check_eq("ex_alu_op",     bus.ex_alu_op,     pipe[0].aop);
         check_eq("mem_write",     bus.mem_write,     pipe[1].mw);
         check_eq("mem_bne",       bus.mem_bne,       pipe[1].bne);
         check_eq("mem_jump",      bus.mem_jump,      pipe[1].jmp);
         check_eq("wb_mem_to_reg", bus.wb_mem_to_reg, pipe[2].m2r);
         check_eq("wb_reg_write",  bus.wb_reg_write,  pipe[2].rw);
         check_eq("wb_rd",         bus.wb_rd,         pipe[2].rd);
`ifdef CTRL_PERF_CNT_EN
         check_eq("stall_cnt",     bus.stall_cnt,     m_stall_cnt);
         check_eq("flush_cnt",     bus.flush_cnt,     m_flush_cnt);
`endif
      end
      last_stall = e_stall;
      if (reset) begin
         for (int i = 0; i < 3; i++) pipe[i] = empty_ent();
`ifdef CTRL_PERF_CNT_EN
         m_stall_cnt = 0;
         m_flush_cnt = 0;
`endif
      end else begin
         pipe[2] = pipe[1];
         pipe[1] = bus.flush ? empty_ent() : pipe[0];
         if (bus.flush || hz || !bus.id_valid) pipe[0] = empty_ent();
         else pipe[0] = ref_decode(int'(bus.id_opcode), int'(bus.id_rd));
`ifdef CTRL_PERF_CNT_EN
         if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
         if (bus.flush && m_flush_cnt < 65535) m_flush_cnt++;
`endif
      end
      @(posedge clk);
      #1;
   endtask

   // Present an instruction and keep it in ID until it is no longer stalled
   task automatic issue(input int op, input int rs, input int rt, input int rd);
      int tries = 0;
      drive(1, op, rs, rt, rd, 0, 0);
      step();
      while (last_stall) begin
         tries++;
         if (tries > 2) begin
            check_eq("issue_stall_bound", tries, 2);
            break;
         end
         step();
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         step();
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) pipe[i] = empty_ent();
      drive(0, 0, 0, 0, 0, 0, 1);
      step();
      checking = 1;
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      check_eq("rst_stall",      bus.stall,        0);
      check_eq("rst_illegal",    bus.illegal,      0);
      check_eq("rst_ex_alu_src", bus.ex_alu_src,   0);
      check_eq("rst_wb_rw",      bus.wb_reg_write, 0);
      check_eq("rst_wb_rd",      bus.wb_rd,        0);

      // Load followed through EX, MEM, WB
      issue(7, 0, 0, 3);
      check_eq("ld_ex_src", bus.ex_alu_src, 2);
      check_eq("ld_ex_op",  bus.ex_alu_op,  0);
      issue(11, 1, 2, 4);
      check_eq("lui_ex_src", bus.ex_alu_src, 3);
      check_eq("lui_ex_op",  bus.ex_alu_op,  7);
      check_eq("ld_mem_wr",  bus.mem_write,  0);
      issue(0, 5, 6, 1);
      check_eq("ld_wb_m2r", bus.wb_mem_to_reg, 1);
      check_eq("ld_wb_rw",  bus.wb_reg_write,  1);
      check_eq("ld_wb_rd",  bus.wb_rd,         3);

      // Opcode sweep
      for (int op = 0; op < 16; op++)
         issue(op, $urandom_range(7), $urandom_range(7), $urandom_range(7));
      idle(3);

      // Load-use: one stall, bubble, consumer one cycle late
      issue(7, 0, 0, 3);
      drive(1, 0, 3, 5, 2, 0, 0);
      #1 check_eq("lu_stall", bus.stall, 1);
      step();
      check_eq("lu_stall_clears", bus.stall, 0);
      step();
      idle(1);
      check_eq("lu_wb_bubble", bus.wb_reg_write, 0);
      idle(1);
      check_eq("lu_wb_late_rw", bus.wb_reg_write, 1);
      check_eq("lu_wb_late_rd", bus.wb_rd, 2);
      issue(7, 0, 0, 3);
      drive(1, 0, 4, 5, 2, 0, 0);
      #1 check_eq("lu_nodep_stall", bus.stall, 0);
      step();
      idle(3);

      // Flush squashes EX and MEM, WB still retires
      issue(0, 1, 1, 1);
      issue(1, 1, 1, 2);
      issue(2, 1, 1, 5);
      drive(1, 4, 0, 0, 6, 1, 0);
      step();
      check_eq("fl_wb_rw",  bus.wb_reg_write, 1);
      check_eq("fl_wb_rd",  bus.wb_rd,        2);
      check_eq("fl_ex_op",  bus.ex_alu_op,    0);
      idle(1);
      check_eq("fl_wb_squashed", bus.wb_reg_write, 0);

      // Flush and hazard together
      issue(7, 0, 0, 3);
      drive(1, 0, 3, 0, 2, 1, 0);
      #1 check_eq("fh_stall", bus.stall, 0);
      step();
      drive(1, 0, 3, 0, 2, 0, 0);
      #1 check_eq("fh_no_extra_stall", bus.stall, 0);
      step();
      idle(3);

      // Reserved opcode
      drive(1, 16, 0, 0, 1, 0, 0);
      #1 check_eq("rsv_illegal", bus.illegal, 1);
      step();
      check_eq("rsv_ex_src", bus.ex_alu_src, 0);
      check_eq("rsv_ex_op",  bus.ex_alu_op,  0);
      drive(0, 16, 0, 0, 1, 0, 0);
      #1 check_eq("rsv_invalid_illegal", bus.illegal, 0);
      idle(3);

      // Reset while a stall is pending
      issue(7, 0, 0, 3);
      drive(1, 0, 3, 0, 2, 0, 1);
      #1 check_eq("rs_pre_stall", bus.stall, 1);
      step();
      drive(1, 0, 3, 0, 2, 0, 0);
      #1;
      check_eq("rs_stall",     bus.stall,        0);
      check_eq("rs_ex_src",    bus.ex_alu_src,   0);
      check_eq("rs_mem_write", bus.mem_write,    0);
      check_eq("rs_wb_rw",     bus.wb_reg_write, 0);
      check_eq("rs_wb_rd",     bus.wb_rd,        0);
      step();
      idle(3);

`ifdef CTRL_PERF_CNT_EN
      drive(0, 0, 0, 0, 0, 0, 1);
      step();
      for (int k = 0; k < 3; k++) begin
         issue(7, 0, 0, 3);
         issue(0, 3, 0, 1);
      end
      idle(2);
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 0, 0, 0, 1, 0);
         step();
      end
      idle(1);
      check_eq("pc_stall_cnt", bus.stall_cnt, 3);
      check_eq("pc_flush_cnt", bus.flush_cnt, 2);
      force dut.stall_cnt_q = 16'hFFFF;
      #1 release dut.stall_cnt_q;
      m_stall_cnt = 65535;
      issue(7, 0, 0, 3);
      issue(0, 3, 0, 1);
      idle(1);
      check_eq("pc_stall_sat", bus.stall_cnt, 65535);
`endif

      // Random traffic; ID is held while stalled
      begin
         int op = 0, rs = 0, rt = 0, rd = 0;
         bit v = 0;
         for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
               v  = ($urandom_range(99) < 85);
               op = $urandom_range(17);
               rs = $urandom_range(3);
               rt = $urandom_range(3);
               rd = $urandom_range(3);
            end
            drive(v, op, rs, rt, rd, ($urandom_range(9) == 0), ($urandom_range(49) == 0));
            step();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
